// File: rtl/dpram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dpram_fifo_ctrl
//  Description : Synchronous FIFO controller for a 2**AW x DW dual-port RAM
//                with synchronous write and asynchronous read. Port A of the
//                RAM is the write side and port B is the read side. Read data
//                is first-word-fall-through: rd_data is ram_dout_b.
//
//  Ports
//    clk         rising-edge clock, shared with the RAM
//    rst_n       asynchronous active-low reset
//    flush       synchronous pointer clear; RAM contents not erased
//    wr_valid    push request          wr_data    push data
//    wr_ready    = ~full               rd_valid   = ~empty
//    rd_ready    pop request           rd_data    = ram_dout_b
//    full/empty  occupancy flags       count      entries held, 0..2**AW
//    ram_we_a    RAM write enable      ram_addr_a RAM write address
//    ram_din_a   RAM write data        ram_we_b   tied 0 (read-only port)
//    ram_addr_b  RAM read address      ram_dout_b RAM async read data
//    overflow    sticky: push attempted while full   (FIFO_ERR_FLAGS_EN only)
//    underflow   sticky: pop attempted while empty   (FIFO_ERR_FLAGS_EN only)
//
//  Build option: define FIFO_ERR_FLAGS_EN to add the overflow/underflow
//  sticky error flags. Without it those ports and registers do not exist.
//
//  Revision    : 1.0 - initial release
// ============================================================================

module dpram_fifo_ctrl #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          wr_valid,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ready,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          ram_we_a,
    output logic [AW-1:0] ram_addr_a,
    output logic [DW-1:0] ram_din_a,
    output logic          ram_we_b,
    output logic [AW-1:0] ram_addr_b,
    input  logic [DW-1:0] ram_dout_b
`ifdef FIFO_ERR_FLAGS_EN
    ,
    output logic          overflow,
    output logic          underflow
`endif
);

    localparam logic [AW:0] c_PTR_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] c_PTR_ZERO = '0;

    // Pointers carry one extra wrap bit so that full and empty are
    // distinguishable when the low address bits coincide.
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    // ------------------------------------------------------------------
    // Status, derived only from registered pointers so that wr_ready and
    // rd_valid never depend combinationally on wr_valid/rd_ready.
    // ------------------------------------------------------------------
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

    assign full     = w_full;
    assign empty    = w_empty;
    assign count    = r_wptr - r_rptr;
    assign wr_ready = ~w_full;
    assign rd_valid = ~w_empty;

    // A push while full is rejected even if a pop happens the same cycle;
    // flush discards both so the RAM sees no write during a flush.
    assign w_push = wr_valid & ~w_full  & ~flush;
    assign w_pop  = rd_ready & ~w_empty & ~flush;

    // ------------------------------------------------------------------
    // RAM interface
    // ------------------------------------------------------------------
    assign ram_we_a   = w_push;
    assign ram_addr_a = r_wptr[AW-1:0];
    assign ram_din_a  = wr_data;
    assign ram_we_b   = 1'b0;
    assign ram_addr_b = r_rptr[AW-1:0];
    assign rd_data    = ram_dout_b;

    // ------------------------------------------------------------------
    // Pointer registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= c_PTR_ZERO;
            r_rptr <= c_PTR_ZERO;
        end else if (flush) begin
            r_wptr <= c_PTR_ZERO;
            r_rptr <= c_PTR_ZERO;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_ONE;
            end
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    // ------------------------------------------------------------------
    // Sticky error flags; only reset or flush clears them.
    // ------------------------------------------------------------------
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (flush) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr_valid && w_full) begin
                r_overflow <= 1'b1;
            end
            if (rd_ready && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dpram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dpram_fifo_ctrl
//  Description : Directed self-checking bench for dpram_fifo_ctrl with a
//                behavioural 16x8 dual-port RAM (sync write, async read).
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_dpram_fifo_ctrl;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          ram_we_a;
    logic [AW-1:0] ram_addr_a;
    logic [DW-1:0] ram_din_a;
    logic          ram_we_b;
    logic [AW-1:0] ram_addr_b;
    logic [DW-1:0] ram_dout_b;
`ifdef FIFO_ERR_FLAGS_EN
    logic          overflow;
    logic          underflow;
`endif

    int n_vec;
    int n_err;

    dpram_fifo_ctrl #(.DW(DW), .AW(AW)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_data    (rd_data),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .ram_we_a   (ram_we_a),
        .ram_addr_a (ram_addr_a),
        .ram_din_a  (ram_din_a),
        .ram_we_b   (ram_we_b),
        .ram_addr_b (ram_addr_b),
        .ram_dout_b (ram_dout_b)
`ifdef FIFO_ERR_FLAGS_EN
        ,
        .overflow   (overflow),
        .underflow  (underflow)
`endif
    );

    // Behavioural RAM: port A synchronous write, port B asynchronous read.
    logic [DW-1:0] mem [16];
    always @(posedge clk) begin
        if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
    end
    assign ram_dout_b = mem[ram_addr_b];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic pop_word();
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        flush    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = '0;
        rd_ready = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;

        // ---------------- reset state ----------------
        step();
        step();
        chk("rst_empty",    {31'd0, empty},      32'd1);
        chk("rst_full",     {31'd0, full},       32'd0);
        chk("rst_count",    {27'd0, count},      32'd0);
        chk("rst_wr_ready", {31'd0, wr_ready},   32'd1);
        chk("rst_rd_valid", {31'd0, rd_valid},   32'd0);
        chk("rst_we_a",     {31'd0, ram_we_a},   32'd0);
        chk("rst_addr_a",   {28'd0, ram_addr_a}, 32'd0);
        chk("rst_addr_b",   {28'd0, ram_addr_b}, 32'd0);
        chk("we_b_tied",    {31'd0, ram_we_b},   32'd0);
`ifdef FIFO_ERR_FLAGS_EN
        chk("rst_ovf",      {31'd0, overflow},   32'd0);
        chk("rst_unf",      {31'd0, underflow},  32'd0);
`endif
        rst_n = 1'b1;
        step();

        // ---------------- 1: single push, FWFT latency ----------------
        wr_valid = 1'b1;
        wr_data  = 8'hAA;
        #1;
        chk("t1_we_a",       {31'd0, ram_we_a},  32'd1);
        chk("t1_din_a",      {24'd0, ram_din_a}, 32'hAA);
        chk("t1_rdv_before", {31'd0, rd_valid},  32'd0);
        step();
        wr_valid = 1'b0;
        chk("t1_rd_valid",   {31'd0, rd_valid},   32'd1);
        chk("t1_rd_data",    {24'd0, rd_data},    32'hAA);
        chk("t1_count",      {27'd0, count},      32'd1);
        chk("t1_addr_a",     {28'd0, ram_addr_a}, 32'd1);
        pop_word();
        chk("t1_empty_after_pop", {31'd0, empty}, 32'd1);
        chk("t1_addr_b",     {28'd0, ram_addr_b}, 32'd1);

        // ---------------- 2: fill to full, overflow attempt ----------------
        for (int i = 0; i < 16; i++) push_word(8'(i));
        chk("t2_full",     {31'd0, full},     32'd1);
        chk("t2_wr_ready", {31'd0, wr_ready}, 32'd0);
        chk("t2_count",    {27'd0, count},    32'd16);
        chk("t2_head",     {24'd0, rd_data},  32'h00);
        wr_valid = 1'b1;
        wr_data  = 8'hFF;
        #1;
        chk("t2_we_a_blocked", {31'd0, ram_we_a}, 32'd0);
        step();
        wr_valid = 1'b0;
        chk("t2_count_hold", {27'd0, count},   32'd16);
        chk("t2_head_kept",  {24'd0, rd_data}, 32'h00);
`ifdef FIFO_ERR_FLAGS_EN
        chk("t2_overflow",   {31'd0, overflow}, 32'd1);
`endif

        // ---------------- 3: push+pop while full ----------------
        wr_valid = 1'b1;
        wr_data  = 8'hEE;
        rd_ready = 1'b1;
        #1;
        chk("t3_we_a_blocked", {31'd0, ram_we_a}, 32'd0);
        step();
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        chk("t3_count",   {27'd0, count},   32'd15);
        chk("t3_rd_data", {24'd0, rd_data}, 32'h01);
        chk("t3_full",    {31'd0, full},    32'd0);

        do_flush();
        chk("fl_count", {27'd0, count}, 32'd0);
        chk("fl_empty", {31'd0, empty}, 32'd1);
`ifdef FIFO_ERR_FLAGS_EN
        chk("fl_ovf_clr", {31'd0, overflow}, 32'd0);
`endif

        // ---------------- 4: streaming across the wrap ----------------
        push_word(8'h30);
        push_word(8'h31);
        push_word(8'h32);
        chk("t4_count_pre", {27'd0, count}, 32'd3);
        for (int i = 0; i < 40; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(8'h33 + i);
            rd_ready = 1'b1;
            #1;
            chk("t4_head",  {24'd0, rd_data}, 32'(8'h30 + i));
            chk("t4_count", {27'd0, count},   32'd3);
            step();
        end
        wr_valid = 1'b0;
        chk("t4_count_post", {27'd0, count}, 32'd3);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t4_drain", {24'd0, rd_data}, 32'(8'h58 + i));
            step();
        end
        rd_ready = 1'b0;
        chk("t4_empty", {31'd0, empty}, 32'd1);

        // ---------------- 5: pop from empty ----------------
        chk("t5_addr_b_pre", {28'd0, ram_addr_b}, 32'd11);
        pop_word();
        chk("t5_addr_b",     {28'd0, ram_addr_b}, 32'd11);
        chk("t5_empty",      {31'd0, empty},      32'd1);
        chk("t5_count",      {27'd0, count},      32'd0);
`ifdef FIFO_ERR_FLAGS_EN
        chk("t5_underflow",  {31'd0, underflow},  32'd1);
`endif

        // ---------------- 6a: async reset mid-operation ----------------
        for (int i = 0; i < 5; i++) push_word(8'(8'h60 + i));
        chk("t6_count5", {27'd0, count}, 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6r_empty",  {31'd0, empty},      32'd1);
        chk("t6r_count",  {27'd0, count},      32'd0);
        chk("t6r_addr_b", {28'd0, ram_addr_b}, 32'd0);
`ifdef FIFO_ERR_FLAGS_EN
        chk("t6r_unf_clr", {31'd0, underflow}, 32'd0);
`endif
        #1;
        rst_n = 1'b1;
        step();
        push_word(8'h5C);
        chk("t6r_data",  {24'd0, rd_data}, 32'h5C);
        chk("t6r_count1", {27'd0, count},  32'd1);
        pop_word();

        // ---------------- 6b: flush mid-operation ----------------
        for (int i = 0; i < 5; i++) push_word(8'(8'h70 + i));
        chk("t6f_count5", {27'd0, count}, 32'd5);
        flush    = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 8'h99;
        rd_ready = 1'b1;
        #1;
        chk("t6f_we_a_flush", {31'd0, ram_we_a}, 32'd0);
        step();
        flush    = 1'b0;
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        chk("t6f_empty",  {31'd0, empty},      32'd1);
        chk("t6f_count",  {27'd0, count},      32'd0);
        chk("t6f_addr_a", {28'd0, ram_addr_a}, 32'd0);
        chk("t6f_addr_b", {28'd0, ram_addr_b}, 32'd0);
        push_word(8'h5C);
        chk("t6f_data",   {24'd0, rd_data}, 32'h5C);
        chk("t6f_count1", {27'd0, count},   32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
